// File: rtl/prime_pkg.sv
// Shared types and constants for the prime generator: FSM state encoding,
// default data width and the first candidate tested.
package prime_pkg;

    localparam int PRIME_W   = 8;
    localparam int MIN_PRIME = 2;

    typedef enum logic [2:0] {
        IDLE,
        TEST,
        EMIT,
        NEXT,
        DONE
    } state_e;

endpackage : prime_pkg

// File: rtl/prime_div_step.sv
// One trial-division step: decides whether the current divisor has passed
// sqrt(cand), and whether it divides cand evenly.
module prime_div_step
    import prime_pkg::*;
#(
    parameter int N = PRIME_W
) (
    input  logic [N-1:0] cand_i,
    input  logic [N-1:0] div_i,
    output logic         is_prime_final_o,
    output logic         is_divisible_o
);

    logic [2*N-1:0] div_sq;
    logic [N-1:0]   safe_div;

    // NOTE: every output gets a value on every path through always_comb, so no latch can be inferred.
    always_comb begin
        div_sq           = {{N{1'b0}}, div_i} * {{N{1'b0}}, div_i};
        // div is zero only while idle; keep the modulo well defined there.
        safe_div         = (div_i == '0) ? N'(1) : div_i;
        is_prime_final_o = div_sq > {{N{1'b0}}, cand_i};
        is_divisible_o   = (cand_i % safe_div) == '0;
    end

endmodule : prime_div_step

// File: rtl/prime_gen.sv
// Sequential prime generator: walks candidates 2..limit, trial-divides one
// divisor per clock and streams each prime out on a valid/ready interface.
module prime_gen
    import prime_pkg::*;
#(
    parameter int N = PRIME_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] limit,
    output logic [N-1:0] p_data,
    output logic         p_valid,
    input  logic         p_ready,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] count
);

    state_e       state_q;
    logic [N-1:0] lim_q;
    logic [N-1:0] cand_q;
    logic [N-1:0] div_q;
    logic [N-1:0] p_data_q;
    logic         p_valid_q;
    logic         busy_q;
    logic         done_q;
    logic [N-1:0] count_q;

    logic         is_prime_final;
    logic         is_divisible;

    prime_div_step #(
        .N (N)
    ) u_div_step (
        .cand_i           (cand_q),
        .div_i            (div_q),
        .is_prime_final_o (is_prime_final),
        .is_divisible_o   (is_divisible)
    );

    // NOTE: all state below updates with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lim_q     <= '0;
            cand_q    <= '0;
            div_q     <= '0;
            p_data_q  <= '0;
            p_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        lim_q   <= limit;
                        cand_q  <= N'(MIN_PRIME);
                        div_q   <= N'(MIN_PRIME);
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= (limit < N'(MIN_PRIME)) ? DONE : TEST;
                    end
                end

                TEST: begin
                    if (is_prime_final) begin
                        p_data_q  <= cand_q;
                        p_valid_q <= 1'b1;
                        state_q   <= EMIT;
                    end else if (is_divisible) begin
                        state_q <= NEXT;
                    end else begin
                        div_q <= div_q + N'(1);
                    end
                end

                EMIT: begin
                    if (p_ready) begin
                        p_valid_q <= 1'b0;
                        count_q   <= count_q + N'(1);
                        state_q   <= NEXT;
                    end
                end

                NEXT: begin
                    // Stopping at all-ones keeps the candidate from wrapping back to 0.
                    if (cand_q >= lim_q || cand_q == '1) begin
                        state_q <= DONE;
                    end else begin
                        cand_q  <= cand_q + N'(1);
                        div_q   <= N'(MIN_PRIME);
                        state_q <= TEST;
                    end
                end

                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign p_data  = p_data_q;
    assign p_valid = p_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign count   = count_q;

endmodule : prime_gen

// File: tb/tb_prime_gen.sv
// Self-checking bench for prime_gen: directed and randomized runs compared
// against a trial-division reference list built inside the bench.
module tb_prime_gen;

    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] limit;
    logic [N-1:0] p_data;
    logic         p_valid;
    logic         p_ready;
    logic         busy;
    logic         done;
    logic [N-1:0] count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // 0: ready low, 1: ready tied high, 2: random ready, 3: 5-cycle stall per prime
    int rdy_mode = 1;
    int stall    = 0;
    logic vprev  = 1'b0;

    int   got[$];
    int   done_cnt;
    int   first_valid_cyc;
    int   first_done_cyc;
    int   start_cyc;
    logic stalled_prev = 1'b0;
    logic [N-1:0] data_prev = '0;

    prime_gen #(
        .N (N)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .limit   (limit),
        .p_data  (p_data),
        .p_valid (p_valid),
        .p_ready (p_ready),
        .busy    (busy),
        .done    (done),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit ref_is_prime(input int v);
        if (v < 2) return 1'b0;
        for (int d = 2; d * d <= v; d++)
            if (v % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    // Consumer-side ready generation, driven just after each rising edge.
    always begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       p_ready = 1'b0;
            1:       p_ready = 1'b1;
            2:       p_ready = 1'($urandom_range(0, 1));
            default: begin
                if (p_valid && !vprev) stall = 5;
                if (stall > 0) begin
                    p_ready = 1'b0;
                    stall--;
                end else begin
                    p_ready = 1'b1;
                end
            end
        endcase
        vprev = p_valid;
    end

    // Monitor on the falling edge: handshakes, done pulses, stall stability.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stalled_prev) begin
                check("stall_valid_held", p_valid, 1);
                check("stall_data_held", p_data, data_prev);
            end
            if (p_valid && p_ready) got.push_back(int'(p_data));
            if (p_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (done) begin
                done_cnt++;
                if (first_done_cyc < 0) first_done_cyc = cyc;
            end
        end
        stalled_prev = rst_n && p_valid && !p_ready;
        data_prev    = p_data;
    end

    task automatic run(input logic [N-1:0] lim, input int mode, input bit extra_start,
                       input string name);
        int exp_q[$];
        int n;
        for (int v = 2; v <= int'(lim); v++)
            if (ref_is_prime(v)) exp_q.push_back(v);

        rdy_mode = mode;
        @(posedge clk);
        #1;
        got.delete();
        done_cnt        = 0;
        first_valid_cyc = -1;
        first_done_cyc  = -1;
        limit           = lim;
        start           = 1'b1;
        start_cyc       = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check({name, "_busy_after_start"}, busy, 1);

        if (extra_start) begin
            @(posedge clk);
            #1;
            limit = 3;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            limit = lim;
        end

        n = 0;
        while (done_cnt == 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done_seen"}, done_cnt != 0, 1);
        repeat (3) @(negedge clk);

        check({name, "_done_pulses"}, done_cnt, 1);
        check({name, "_busy_after_done"}, busy, 0);
        check({name, "_count"}, count, exp_q.size());
        check({name, "_num_primes"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check({name, "_prime"}, got[i], exp_q[i]);
    endtask

    initial begin
        int lim_r;
        int n;
        bit seen5;

        rst_n   = 1'b0;
        start   = 1'b0;
        limit   = '0;
        p_ready = 1'b1;
        first_valid_cyc = -1;
        first_done_cyc  = -1;
        done_cnt        = 0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_p_valid", p_valid, 0);
        check("rst_p_data", p_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", count, 0);
        rst_n = 1'b1;

        run(8'd10, 1, 1'b0, "lim10");

        run(8'd1, 1, 1'b0, "lim1");
        check("lim1_done_latency", first_done_cyc - start_cyc, 2);
        check("lim1_no_valid", first_valid_cyc, -1);
        run(8'd0, 1, 1'b0, "lim0");
        check("lim0_done_latency", first_done_cyc - start_cyc, 2);

        run(8'd2, 1, 1'b0, "lim2");
        check("lim2_valid_latency", first_valid_cyc - start_cyc, 2);

        run(8'd20, 3, 1'b0, "bp20");

        run(8'd255, 1, 1'b0, "lim255");
        check("lim255_last", got.size() > 0 ? got[got.size()-1] : 0, 251);

        for (int r = 0; r < 3; r++) begin
            lim_r = $urandom_range(0, 80);
            run(N'(lim_r), 2, 1'b0, "rand");
        end

        // Reset while a prime (5) is being offered.
        rdy_mode = 1;
        @(posedge clk);
        #1;
        limit = 10;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen5 = 1'b0;
        n = 0;
        while (!seen5 && n < 200) begin
            @(negedge clk);
            seen5 = p_valid && (p_data == 5);
            n++;
        end
        check("mid_reach_emit5", seen5, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_p_valid", p_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_p_data", p_data, 0);
        #1;
        rst_n = 1'b1;

        run(8'd10, 1, 1'b1, "restart10");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_prime_gen

// File: doc/prime_gen.md
Name: prime_gen

Overview:
Sequential prime-number generator. It is the producer side of the team's combinational primality checker. On a start pulse it walks candidates from 2 up to a programmable limit and tests each one by trial division, one divisor per clock. Each prime found is emitted on a valid/ready stream. A downstream primality checker or a scoreboard consumes the stream.

Parameters:
N, 8, data width of candidates, limit and emitted primes (N >= 3)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin generation; sampled only in IDLE
limit  input  N  highest candidate to test (inclusive); captured on accepted start
p_data  output  N  emitted prime; valid while p_valid=1
p_valid  output  1  p_data holds a prime awaiting acceptance
p_ready  input  1  consumer accepts p_data when p_valid && p_ready at a rising edge
busy  output  1  high from the cycle after an accepted start until DONE is left
done  output  1  one-cycle pulse when generation completes
count  output  N  number of primes accepted since the last start

Behaviour:
- Reset (rst_n=0, async): state=IDLE, p_data=0, p_valid=0, busy=0, done=0, count=0; cand, div and lim_q are cleared.
- Reset mid-operation aborts immediately. Any pending p_valid drops, and no partial state survives.
- States are IDLE, TEST, EMIT, NEXT, DONE.
- IDLE:
  - On start=1: lim_q<=limit, cand<=2, div<=2, count<=0, busy<=1.
  - If limit<2, go to DONE; otherwise go to TEST.
  - start is ignored in every other state.
- TEST: one divisor evaluated per cycle.
  - The product div*div is computed at 2N bits, so there is no overflow.
  - If div*div > cand: cand is prime, p_data<=cand, p_valid<=1, go to EMIT.
  - Else if cand % div == 0: composite, go to NEXT.
  - Else div<=div+1 and stay in TEST.
- EMIT: p_valid=1 and p_data is held stable until p_ready=1 at a clock edge. On acceptance: p_valid<=0, count<=count+1, go to NEXT. p_ready has no effect outside EMIT.
- NEXT:
  - If cand >= lim_q or cand == 2^N-1, go to DONE. The candidate never wraps.
  - Otherwise cand<=cand+1, div<=2, go to TEST.
- DONE: done=1 for exactly one cycle, busy<=0, then go to IDLE. count holds its value until the next accepted start.
- Latency:
  - Accepted start to first p_valid (cand=2) is 2 cycles: the IDLE->TEST edge, then the TEST->EMIT edge.
  - A prime p costs floor(sqrt(p))-0 TEST cycles (div runs 2..floor(sqrt p)+1).
  - A composite costs (smallest factor - 1) TEST cycles.
- Simultaneous events: start asserted in the same cycle DONE exits is ignored. start is honoured only from the following IDLE cycle.
- Outputs are registered. There is no combinational path from p_ready to p_valid.

Decomposition:
- Shared package prime_pkg holds:
  - the state enum (IDLE, TEST, EMIT, NEXT, DONE);
  - the default width constant PRIME_W=8;
  - the constant MIN_PRIME=2.
- One sub-module, prime_div_step, is natural. It is combinational and takes cand and div. It returns is_prime_final (div*div > cand) and is_divisible (cand % div == 0). The FSM and registers stay in prime_gen.

Test Plan:
- limit=10, p_ready tied 1 -> p_data stream 2,3,5,7 with one p_valid cycle each; done pulses once; final count=4; busy low after done.
- limit=1 (also limit=0) -> no p_valid ever; done pulses 2 cycles after start; count=0.
- limit=2 -> single prime 2 with p_valid at cycle start+2; done follows; count=1.
- Backpressure: limit=20, hold p_ready=0 for 5 cycles whenever p_valid rises -> p_data stable while stalled; stream 2,3,5,7,11,13,17,19 in order with no loss or duplication; count=8.
- N=8, limit=255 -> 54 primes, last p_data=251; candidate stops at 255 without wrap; done pulses once.
- Assert rst_n=0 while in EMIT with p_data=5 -> p_valid, busy, count drop to 0 immediately. A start pulse pulsed during busy on a fresh run with limit=10 is ignored (stream unchanged, count=4).
